// File: rtl/imm_enc_pkg.sv
// rtl/imm_enc_pkg.sv - shared format codes, opcodes and immediate range limits for the immediate encoder
package imm_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_LI  = 3'd6,
        FMT_RSV = 3'd7
    } fmt_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } li_state_e;

    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_OPIMM = 7'h13;

    localparam int signed I_MIN = -2048;
    localparam int signed I_MAX = 2047;
    localparam int signed B_MIN = -4096;
    localparam int signed B_MAX = 4094;
    localparam int signed J_MIN = -1048576;
    localparam int signed J_MAX = 1048574;

    function automatic logic imm_in_range(input logic [31:0] imm,
                                          input int signed lo,
                                          input int signed hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0]  rd,
                                             input logic [4:0]  rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, OP_OPIMM};
    endfunction

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - combinational RV32I field packer with encodability check (LI first word when IMM_ENC_LI_EXPAND_EN)
module imm_pack
    import imm_enc_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_err
);

`ifdef IMM_ENC_LI_EXPAND_EN
    // Rounding by 0x800 compensates for the sign-extended low 12 bits added by the ADDI.
    logic [31:0] w_li_sum;
    assign w_li_sum = i_imm + 32'h0000_0800;
`endif

    always_comb begin
        o_instr = RESET_INSTR;
        o_err   = 1'b1;
        case (fmt_e'(i_fmt))
            FMT_R: begin
                o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                o_err   = 1'b0;
            end
            FMT_I: begin
                o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_err   = !imm_in_range(i_imm, I_MIN, I_MAX);
            end
            FMT_S: begin
                o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_err   = !imm_in_range(i_imm, I_MIN, I_MAX);
            end
            FMT_B: begin
                o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], i_opcode};
                o_err   = !imm_in_range(i_imm, B_MIN, B_MAX) || i_imm[0];
            end
            FMT_U: begin
                o_instr = {i_imm[31:12], i_rd, i_opcode};
                o_err   = |i_imm[11:0];
            end
            FMT_J: begin
                o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_err   = !imm_in_range(i_imm, J_MIN, J_MAX) || i_imm[0];
            end
`ifdef IMM_ENC_LI_EXPAND_EN
            FMT_LI: begin
                if (imm_in_range(i_imm, I_MIN, I_MAX)) begin
                    o_instr = enc_addi(i_rd, 5'd0, i_imm[11:0]);
                end else begin
                    o_instr = {w_li_sum[31:12], i_rd, OP_LUI};
                end
                o_err = 1'b0;
            end
`endif
            default: begin
                o_instr = RESET_INSTR;
                o_err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - registered RV32I instruction encoder; LI expansion into LUI+ADDI under IMM_ENC_LI_EXPAND_EN
module imm_encoder
    import imm_enc_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013,
    parameter int          CHECK_RANGE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
);

    logic [31:0] w_pack_instr;
    logic        w_pack_err;
    logic        w_err;
    logic        w_accept;
    logic        w_out_xfer;

    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic        r_out_err;

    imm_pack #(
        .RESET_INSTR (RESET_INSTR)
    ) u_pack (
        .i_fmt    (in_fmt),
        .i_opcode (in_opcode),
        .i_rd     (in_rd),
        .i_rs1    (in_rs1),
        .i_rs2    (in_rs2),
        .i_funct3 (in_funct3),
        .i_funct7 (in_funct7),
        .i_imm    (in_imm),
        .o_instr  (w_pack_instr),
        .o_err    (w_pack_err)
    );

    assign w_err      = (CHECK_RANGE != 0) && w_pack_err;
    assign w_accept   = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    assign out_valid  = r_out_valid;
    assign out_instr  = r_out_instr;
    assign out_err    = r_out_err;

`ifdef IMM_ENC_LI_EXPAND_EN
    li_state_e   r_state;
    logic [4:0]  r_li_rd;
    logic [11:0] r_li_lo;
    logic        w_li_split;

    assign w_li_split = (in_fmt == FMT_LI) && !imm_in_range(in_imm, I_MIN, I_MAX);
    assign in_ready   = (r_state == ST_IDLE) && (!r_out_valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_instr <= RESET_INSTR;
            r_out_err   <= 1'b0;
            r_state     <= ST_IDLE;
            r_li_rd     <= 5'd0;
            r_li_lo     <= 12'd0;
        end else if (r_state == ST_SECOND) begin
            // The LUI stays valid until taken, then the ADDI replaces it with no bubble.
            if (w_out_xfer) begin
                r_out_instr <= enc_addi(r_li_rd, r_li_rd, r_li_lo);
                r_out_err   <= 1'b0;
                r_state     <= ST_IDLE;
            end
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_pack_instr;
            r_out_err   <= w_err;
            if (w_li_split) begin
                r_state <= ST_SECOND;
                r_li_rd <= in_rd;
                r_li_lo <= in_imm[11:0];
            end
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end
`else
    assign in_ready = !r_out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_instr <= RESET_INSTR;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_pack_instr;
            r_out_err   <= w_err;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - directed self-checking bench for imm_encoder
module tb_imm_encoder;
    import imm_enc_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    int checks;
    int errors;

    typedef struct packed {
        logic [2:0]  f;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    imm_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm);
        in_fmt    = f;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    task automatic add_vec(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm,
                           input logic [31:0] exp, input logic exp_err);
        vec_t v;
        v.f = f; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp = exp; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic test_reset;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %h exp 00000013", out_instr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", out_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_formats;
        add_vec(FMT_I,   7'h67, 5'd13, 5'd31, 5'd0, 3'd7, 7'h00, 32'h0000_06cd, 32'h6cdf_f6e7, 1'b0);
        add_vec(FMT_U,   7'h37, 5'd12, 5'd0,  5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_5637, 1'b0);
        add_vec(FMT_J,   7'h6f, 5'd18, 5'd0,  5'd0, 3'd0, 7'h00, 32'h0009_9666, 32'h6669_996f, 1'b0);
        add_vec(FMT_R,   7'h33, 5'd1,  5'd2,  5'd3, 3'd0, 7'h20, 32'h0000_0000, 32'h4031_00b3, 1'b0);
        add_vec(FMT_S,   7'h23, 5'd31, 5'd2,  5'd5, 3'd2, 7'h00, 32'hffff_fffc, 32'hfe51_2e23, 1'b0);
        add_vec(FMT_B,   7'h63, 5'd0,  5'd1,  5'd2, 3'd0, 7'h00, 32'hffff_fff8, 32'hfe20_8ce3, 1'b0);
        add_vec(FMT_B,   7'h63, 5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'h0000_0751, 32'h7400_0863, 1'b1);
        add_vec(FMT_I,   7'h13, 5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h8000_0093, 1'b1);
        add_vec(FMT_U,   7'h37, 5'd12, 5'd0,  5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h1234_5637, 1'b1);
        add_vec(FMT_I,   7'h13, 5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'h0000_07ff, 32'h7ff0_0013, 1'b0);
        add_vec(FMT_I,   7'h13, 5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'hffff_f800, 32'h8000_0013, 1'b0);
        add_vec(FMT_B,   7'h63, 5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'h0000_0ffe, 32'h7e00_0fe3, 1'b0);
        add_vec(FMT_B,   7'h63, 5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'h0000_1000, 32'h8000_0063, 1'b1);
        add_vec(FMT_J,   7'h6f, 5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'hfff0_0000, 32'h8000_006f, 1'b0);
        add_vec(FMT_J,   7'h6f, 5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h8000_006f, 1'b1);
        add_vec(FMT_RSV, 7'h33, 5'd7,  5'd7,  5'd7, 3'd7, 7'h7f, 32'h1234_5678, 32'h0000_0013, 1'b1);
`ifndef IMM_ENC_LI_EXPAND_EN
        add_vec(FMT_LI,  7'h13, 5'd10, 5'd0,  5'd0, 3'd0, 7'h00, 32'hffff_fffb, 32'h0000_0013, 1'b1);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            set_req(vecs[i].f, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                    vecs[i].f3, vecs[i].f7, vecs[i].imm);
            in_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fmt_valid[%0d] got %b exp 1", i, out_valid); end
            checks++; if (out_instr !== vecs[i].exp) begin errors++; $display("FAIL fmt_instr[%0d] got %h exp %h", i, out_instr, vecs[i].exp); end
            checks++; if (out_err !== vecs[i].exp_err) begin errors++; $display("FAIL fmt_err[%0d] got %b exp %b", i, out_err, vecs[i].exp_err); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmt_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_stall;
        @(negedge clk);
        out_ready = 1'b0;
        set_req(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800);
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_instr !== 32'h8000_0093) begin errors++; $display("FAIL stall_first got %h exp 80000093", out_instr); end
        @(negedge clk);
        set_req(FMT_U, 7'h37, 5'd12, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", c, out_valid); end
            checks++; if (out_instr !== 32'h8000_0093) begin errors++; $display("FAIL stall_instr[%0d] got %h exp 80000093", c, out_instr); end
            checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL stall_err[%0d] got %b exp 1", c, out_err); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0", c, in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_instr !== 32'h1234_5637) begin errors++; $display("FAIL release_instr got %h exp 12345637", out_instr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL release_err got %b exp 0", out_err); end
        @(negedge clk);
        set_req(FMT_R, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'h0);
        @(posedge clk); #1;
        checks++; if (out_instr !== 32'h4031_00b3) begin errors++; $display("FAIL b2b_instr got %h exp 403100b3", out_instr); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

`ifdef IMM_ENC_LI_EXPAND_EN
    task automatic test_li;
        @(negedge clk);
        out_ready = 1'b1;
        set_req(FMT_LI, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5fff);
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_instr !== 32'h1234_62b7) begin errors++; $display("FAIL li_lui got %h exp 123462b7", out_instr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL li_lui_err got %b exp 0", out_err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL li_second_ready got %b exp 0", in_ready); end
        @(negedge clk);
        set_req(FMT_LI, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'hffff_fffb);
        @(posedge clk); #1;
        checks++; if (out_instr !== 32'hfff2_8293) begin errors++; $display("FAIL li_addi got %h exp fff28293", out_instr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL li_idle_ready got %b exp 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_instr !== 32'hffb0_0513) begin errors++; $display("FAIL li_short got %h exp ffb00513", out_instr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL li_short_err got %b exp 0", out_err); end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL li_drain got %b exp 0", out_valid); end
    endtask
`endif

    task automatic test_async_reset;
        @(negedge clk);
        out_ready = 1'b0;
`ifdef IMM_ENC_LI_EXPAND_EN
        set_req(FMT_LI, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5fff);
`else
        set_req(FMT_I, 7'h67, 5'd13, 5'd31, 5'd0, 3'd7, 7'h00, 32'h0000_06cd);
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", out_valid); end
        checks++; if (out_instr !== 32'h0000_0013) begin errors++; $display("FAIL arst_instr got %h exp 00000013", out_instr); end
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_no_addi[%0d] got %b exp 0", c, out_valid); end
        end
        @(negedge clk);
        set_req(FMT_I, 7'h67, 5'd13, 5'd31, 5'd0, 3'd7, 7'h00, 32'h0000_06cd);
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_instr !== 32'h6cdf_f6e7) begin errors++; $display("FAIL arst_next got %h exp 6cdff6e7", out_instr); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_next_valid got %b exp 1", out_valid); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_req(3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);
        test_reset;
        test_formats;
        test_stall;
`ifdef IMM_ENC_LI_EXPAND_EN
        test_li;
`endif
        test_async_reset;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
